// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: compares the newest len received bits
// against a loaded pattern, with Mealy and registered match outputs and a saturating match count.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1101),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y,
    output logic               y_q,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    // The oldest history bit can never reach a MAX_LEN-bit compare, so it is not stored.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] window;
    logic               bits_eq;
    logic               fill_ok;
    logic               cfg_len_bad;

    assign window = {hist, din};

    always_comb begin
        // NOTE: default before the loop so every path assigns bits_eq (no latch).
        bits_eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len) && window[i] != pattern[i]) begin
                bits_eq = 1'b0;
            end
        end
    end

    assign fill_ok     = (int'(fill) + 1) >= int'(len);
    assign y           = din_valid & ~cfg_load & ~rst & ~cfg_err & fill_ok & bits_eq;
    assign cfg_len_bad = (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= RST_PATTERN;
            len         <= LEN_W'(RST_LEN);
            overlap     <= RST_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else if (cfg_load) begin
            pattern     <= cfg_pattern;
            len         <= cfg_len;
            overlap     <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            cfg_err     <= cfg_len_bad;
        end else if (din_valid) begin
            hist <= window[MAX_LEN-2:0];
            if (y && !overlap) begin
                fill <= '0;
            end else if (fill != LEN_W'(MAX_LEN)) begin
                fill <= fill + LEN_W'(1);
            end
            if (y && match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed vector table, hand-written corner sequences and
// randomized traffic, all scored against a queue-based reference model.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               y;
    logic               y_q;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .y           (y),
        .y_q         (y_q),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the list of accepted bits since the last clear, oldest first.
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    int         m_cnt;
    bit         m_err;
    bit         m_yq;
    logic       last_y;

    typedef struct {
        logic       r;
        logic       dv;
        logic       d;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       ey;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, score y mid-cycle, registered outputs after the edge.
    task automatic step(input logic r, input logic dv, input logic d, input logic ld,
                        input logic [7:0] pat, input logic [3:0] ln, input logic ov);
        bit ey;
        bit b;
        rst = r; din_valid = dv; din = d; cfg_load = ld;
        cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov;
        @(negedge clk);
        ey = 1'b0;
        if (!r && !ld && dv && !m_err && (m_bits.size() + 1 >= m_len)) begin
            ey = 1'b1;
            for (int k = 0; k < m_len; k++) begin
                b = (k == 0) ? d : m_bits[m_bits.size() - k];
                if (b != m_pat[k]) ey = 1'b0;
            end
        end
        last_y = y;
        check("y", {31'b0, y}, {31'b0, ey});
        if (r) begin
            m_bits.delete(); m_pat = 8'h0D; m_len = 4; m_ov = 1'b1; m_cnt = 0; m_err = 1'b0;
        end else if (ld) begin
            m_bits.delete(); m_pat = pat; m_len = int'(ln); m_ov = ov; m_cnt = 0;
            m_err = (ln == 0) || (int'(ln) > MAX_LEN);
        end else if (dv) begin
            m_bits.push_back(d);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            if (ey && !m_ov) m_bits.delete();
            if (ey && m_cnt < 255) m_cnt++;
        end
        m_yq = ey;
        @(posedge clk);
        #1;
        check("y_q", {31'b0, y_q}, {31'b0, m_yq});
        check("match_count", 32'(match_count), 32'(m_cnt));
        check("cfg_err", {31'b0, cfg_err}, {31'b0, m_err});
    endtask

    task automatic add(input logic r, input logic dv, input logic d, input logic ld,
                       input logic [7:0] pat, input logic [3:0] ln, input logic ov,
                       input logic ey, input int ecnt);
        vec_t v;
        v.r = r; v.dv = dv; v.d = d; v.ld = ld; v.pat = pat; v.len = ln; v.ov = ov;
        v.ey = ey; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic addb(input logic d, input logic ey, input int ecnt);
        add(1'b0, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, ey, ecnt);
    endtask

    task automatic addi(input logic d, input int ecnt);
        add(1'b0, 1'b0, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ecnt);
    endtask

    task automatic addl(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
        add(1'b0, 1'b0, 1'b0, 1'b1, pat, ln, ov, 1'b0, 0);
    endtask

    initial begin
        logic [7:0] rp;
        logic [3:0] rl;

        rst = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        m_pat = 8'h0D; m_len = 4; m_ov = 1'b1; m_cnt = 0; m_err = 1'b0; m_yq = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then default 1101 overlapping
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 0);
        addb(1, 0, 0); addb(1, 0, 0); addb(0, 0, 0); addb(1, 1, 1);
        addb(1, 0, 1); addb(0, 0, 1); addb(1, 1, 2);
        // Non-overlapping 1101
        addl(8'h0D, 4'd4, 1'b0);
        addb(1, 0, 0); addb(1, 0, 0); addb(0, 0, 0); addb(1, 1, 1);
        addb(1, 0, 1); addb(0, 0, 1); addb(1, 0, 1);
        addb(1, 0, 1); addb(1, 0, 1); addb(0, 0, 1); addb(1, 1, 2);
        // Gaps with din toggling do not break a partial match
        addl(8'h0D, 4'd4, 1'b1);
        addb(1, 0, 0); addi(1, 0); addi(0, 0); addi(1, 0);
        addb(1, 0, 0); addi(0, 0); addi(1, 0); addi(0, 0);
        addb(0, 0, 0); addi(1, 0); addi(1, 0); addi(0, 0);
        addb(1, 1, 1);
        // Length 1, then length MAX_LEN
        addl(8'h01, 4'd1, 1'b1);
        addb(1, 1, 1); addb(0, 0, 1); addb(1, 1, 2); addb(1, 1, 3);
        addl(8'hFF, 4'd8, 1'b1);
        for (int i = 1; i <= 7; i++) addb(1, 0, 0);
        addb(1, 1, 1); addb(1, 1, 2);
        // Illegal length suppresses matching
        addl(8'h01, 4'd0, 1'b1);
        addb(1, 0, 0); addb(1, 0, 0); addb(0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].dv, vecs[i].d, vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ov);
            check($sformatf("tbl_y[%0d]", i), {31'b0, last_y}, {31'b0, vecs[i].ey});
            check($sformatf("tbl_cnt[%0d]", i), 32'(match_count), 32'(vecs[i].ecnt));
        end

        // len=0 stays disabled for 20 random bits
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'd0, 1'b1);
        check("err_len0", {31'b0, cfg_err}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0);
            check("err_y_stuck", {31'b0, last_y}, 32'd0);
        end
        check("err_cnt_zero", 32'(match_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0D, 4'd9, 1'b1);
        check("err_len9", {31'b0, cfg_err}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0D, 4'd4, 1'b1);
        check("err_cleared", {31'b0, cfg_err}, 32'd0);

        // Counter saturation
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        check("sat_cnt", 32'(match_count), 32'd255);

        // Reset mid-match discards the partial pattern
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0D, 4'd4, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        check("rst_no_y", {31'b0, last_y}, 32'd0);
        check("rst_cnt", 32'(match_count), 32'd0);

        // Randomized traffic with occasional reconfiguration and reset
        for (int i = 0; i < 1500; i++) begin
            rp = 8'($urandom);
            rl = 4'($urandom_range(0, 9));
            if (rl > 4'd3 && $urandom_range(0, 1) == 0) rl = 4'($urandom_range(1, 3));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 59) == 0), rp, rl, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
